// File: rtl/bus_packer.sv
// Compacts valid words from masked input beats into dense output words; full words emit one edge after staging.
// Backpressure holds data_out/word_cnt stable; a flush drains a zero-padded partial word, then pulses flush_done.
module bus_packer #(
  parameter  int BUS_SIZE  = 16,
  parameter  int WORD_SIZE = 4,
  localparam int WORD_NUM  = BUS_SIZE / WORD_SIZE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BUS_SIZE-1:0] data_in,
  input  logic [WORD_NUM-1:0] control_in,
  input  logic                valid_in,
  output logic                ready_out,
  output logic [BUS_SIZE-1:0] data_out,
  output logic                valid_out,
  input  logic                ready_in,
  output logic [2:0]          word_cnt,
  input  logic                flush,
  output logic                flush_done
);

  localparam int         STG = 2 * WORD_NUM - 1;
  localparam logic [2:0] WN  = 3'(WORD_NUM);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                            state_q, state_d;
  logic [STG-1:0][WORD_SIZE-1:0]     stg_q, stg_d;
  logic [2:0]                        c_q, c_d;
  logic [BUS_SIZE-1:0]               data_q, data_d;
  logic                              valid_q, valid_d;
  logic [2:0]                        cnt_q, cnt_d;
  logic                              done_q, done_d;
  logic                              slot_free;
  logic                              accept;
  logic [2:0]                        pos;

  assign ready_out  = reset && (state_q == RUN) && (c_q < WN);
  assign accept     = valid_in && ready_out;
  assign slot_free  = !valid_q || ready_in;
  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign word_cnt   = cnt_q;
  assign flush_done = done_q;

  always_comb begin
    state_d = state_q;
    stg_d   = stg_q;
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    pos     = c_q;

    // Emit decisions look only at the count held at the start of the cycle.
    if (slot_free) begin
      valid_d = 1'b0;
      if (c_q >= WN) begin
        for (int i = 0; i < WORD_NUM; i++) data_d[i*WORD_SIZE +: WORD_SIZE] = stg_q[i];
        valid_d = 1'b1;
        cnt_d   = WN;
        for (int i = 0; i < STG - WORD_NUM; i++) stg_d[i] = stg_q[i+WORD_NUM];
        for (int i = STG - WORD_NUM; i < STG; i++) stg_d[i] = '0;
        pos = c_q - WN;
      end else if (state_q == FLUSH && c_q != 3'd0) begin
        for (int i = 0; i < WORD_NUM; i++)
          data_d[i*WORD_SIZE +: WORD_SIZE] = (3'(i) < c_q) ? stg_q[i] : '0;
        valid_d = 1'b1;
        cnt_d   = c_q;
        stg_d   = '0;
        pos     = 3'd0;
      end else if (state_q == FLUSH) begin
        done_d  = 1'b1;
        state_d = RUN;
      end
    end

    if (state_q == RUN && flush) state_d = FLUSH;

    // Appended words land behind whatever survived the shift above.
    if (accept) begin
      for (int i = 0; i < WORD_NUM; i++) begin
        if (control_in[i]) begin
          if (pos < 3'(STG)) stg_d[pos] = data_in[i*WORD_SIZE +: WORD_SIZE];
          pos = pos + 3'd1;
        end
      end
    end
    c_d = pos;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      stg_q   <= '0;
      c_q     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stg_q   <= stg_d;
      c_q     <= c_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

endmodule
